a5_burst_cipher: RTL

//  Sequencer and consumer for the A5/1 keystream generator. Loads key/frame,

---
 rtl/a5_burst_cipher.sv | 97 +++++++++
 1 files changed

// File: rtl/a5_burst_cipher.sv
// a5_burst_cipher: sequences A5/1 load, injection, mixing and optional skip, then XORs one keystream burst onto a handshaked bit stream
module a5_burst_cipher #(
  parameter int KEY_BITS   = 64,
  parameter int FRAME_BITS = 22,
  parameter int MIX_CYCLES = 100,
  parameter int BURST_BITS = 114
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  dir,
  input  logic [KEY_BITS-1:0]   key,
  input  logic [FRAME_BITS-1:0] frame,
  output logic                  busy,
  output logic                  done,
  output logic                  gen_load,
  output logic                  gen_clk_en,
  output logic [KEY_BITS-1:0]   gen_key,
  output logic [FRAME_BITS-1:0] gen_frame,
  input  logic                  gen_d,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_bit,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_bit
);
  localparam int INJ  = KEY_BITS + FRAME_BITS;
  localparam int MAXA = INJ > MIX_CYCLES ? INJ : MIX_CYCLES;
  localparam int MAXP = MAXA > BURST_BITS ? MAXA : BURST_BITS;
  localparam int CW   = $clog2(MAXP + 1);
  typedef enum logic [2:0] {IDLE, LOAD, INJECT, MIX, SKIP, XFER, FLUSH, DONE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic dir_q;
  logic last;
  logic acc;
  assign last       = cnt == CW'(1);
  assign in_ready   = (state == XFER) & (!out_valid | out_ready);
  assign acc        = in_valid & in_ready;
  assign gen_clk_en = (state == INJECT) | (state == MIX) | (state == SKIP) | acc;
  assign busy       = state != IDLE;
  assign done       = state == DONE;
  assign gen_load   = state == LOAD;
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      dir_q     <= 1'b0;
      out_valid <= 1'b0;
      out_bit   <= 1'b0;
      gen_key   <= '0;
      gen_frame <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state     <= LOAD;
          gen_key   <= key;
          gen_frame <= frame;
          dir_q     <= dir;
        end
        LOAD: begin
          state <= INJECT;
          cnt   <= CW'(INJ);
        end
        INJECT: begin
          state <= last ? MIX : INJECT;
          cnt   <= last ? CW'(MIX_CYCLES) : cnt - 1'b1;
        end
        MIX: begin
          state <= last ? (dir_q ? SKIP : XFER) : MIX;
          cnt   <= last ? CW'(BURST_BITS) : cnt - 1'b1;
        end
        SKIP: begin
          state <= last ? XFER : SKIP;
          cnt   <= last ? CW'(BURST_BITS) : cnt - 1'b1;
        end
        XFER: begin
          // the generator only steps on an accept, so stalls freeze the keystream with the data
          if (acc) begin
            out_bit   <= in_bit ^ gen_d;
            out_valid <= 1'b1;
            cnt       <= cnt - 1'b1;
            state     <= last ? FLUSH : XFER;
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        FLUSH: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= DONE;
        end
        DONE: state <= IDLE;
      endcase
    end
  end
endmodule
